pim_alu_ctrl: RTL
=================

# pim_alu_ctrl

Sequencer for the PIM ALU datapath that executes vector commands of the form dst[i] = src_a[i] OP src_b[i] for i = 0 to len-1 against a single-port local memory bank. It accepts one command at a time over a valid/ready handshake and issues operand reads and result writes to the bank. It instantiates the ALU internally and sits between the PIM command front-end and the memory bank.

## Interface
Parameters:
- DATA_WIDTH, 32, word width of memory and ALU
- ADDR_WIDTH, 8, memory word-address width
- LEN_WIDTH, 8, width of the element-count field

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- cmd_src_a  in  ADDR_WIDTH  base address of operand A vector
- cmd_src_b  in  ADDR_WIDTH  base address of operand B vector
- cmd_dst  in  ADDR_WIDTH  base address of result vector
- cmd_len  in  LEN_WIDTH  element count; 0 is legal
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  DATA_WIDTH  write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch op, src_a, src_b, dst and len, and clear idx. Go to DONE if cmd_len==0. Otherwise go to RD_A.
- RD_A: mem_rd_en=1, mem_rd_addr=src_a+idx. Next state is RD_B.
- RD_B: mem_rd_en=1, mem_rd_addr=src_b+idx. Capture mem_rd_data (A operand) into reg_a. Next state is WR.
- WR: drive the ALU with a=reg_a, b=mem_rd_data (B operand) and the latched op. Assert mem_wr_en=1 with mem_wr_addr=dst+idx and mem_wr_data=ALU result.
  - If idx==len-1, go to DONE.
  - Otherwise increment idx and go to RD_A.
- DONE: done=1 for one cycle, then go to IDLE.
- Reads and writes never occur in the same cycle, so a single-port bank is sufficient.
- Arithmetic and width rules:
  - Address sums are modulo 2^ADDR_WIDTH; they wrap silently.
  - ALU results are modulo 2^DATA_WIDTH; no carry or borrow output.
  - idx is LEN_WIDTH bits wide.
- Command inputs are sampled only on the handshake cycle. Later changes have no effect on the command in flight.
- Overlapping src/dst ranges are legal. Element i is written before element i+1 is read, so in-place operation (dst==src_a) is well defined.

## Timing
- Reset, rst_n low at a rising edge:
  - state=IDLE, idx=0, reg_a=0 and all latched fields=0.
  - Outputs: cmd_ready=1, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, addresses=0, mem_wr_data=0.
- mem_rd_en and mem_wr_en are gated with rst_n. No memory access is issued in any cycle where rst_n=0, including a mid-command reset. The aborted command is dropped with no done pulse.
- Handshake: transfer occurs on the edge where cmd_valid&cmd_ready=1. A valid command held high during busy waits; it is not dropped.
- Latency, with the accept edge as cycle 0:
  - Element k has RD_A at 3k+1, RD_B at 3k+2 and WR at 3k+3.
  - done is high in cycle 3N+1; cmd_ready returns high in cycle 3N+2.
  - For len=0, done is high in cycle 1.
- Throughput is 3 cycles per element. The minimum gap between accepts is 3N+2 cycles.

## Structure
- Shared package pim_pkg holds:
  - op encodings: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - the controller state enum
- Sub-module: one instance of the existing ALU, parameterised with DATA_WIDTH, driven combinationally in WR.
- No other sub-modules. FSM, idx counter and address adders are local.

## Test plan
- ADD, len=4, src_a=0x00 holding {1,2,3,4}, src_b=0x10 holding {10,20,30,40}, dst=0x20 -> mem[0x20..0x23]={11,22,33,44}; done in cycle 13; exactly 8 reads and 4 writes.
- SUB, len=1, A=0, B=1 -> result 0xFFFFFFFF (wraps).
- len=0, any op -> done in cycle 1; no mem_rd_en or mem_wr_en ever asserted; busy high for 1 cycle.
- Address wrap: src_a=0xFE, src_b=0x40, dst=0xFF, len=3, OR -> reads 0xFE,0xFF,0x00 for A; writes 0xFF,0x00,0x01.
- Back-to-back: second command held valid during the first (len=2) -> second accepted in cycle 8; first done in cycle 7; both results correct.
- Reset asserted during WR of element 1 of a len=4 command -> no write in the reset cycle; outputs at reset values next cycle; mem[dst+1..] unchanged; no done pulse; a new command is accepted normally afterward.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared definitions for the PIM ALU sequencer: ALU op encodings and controller states.
package pim_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/pim_alu_ctrl_alu.sv
// Combinational two-operand ALU; results wrap modulo 2^DATA_WIDTH.
module pim_alu_ctrl_alu
  import pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pim_alu_ctrl.sv
// Vector command sequencer: dst[i] = src_a[i] OP src_b[i], three cycles per element
// against a single-port bank with one-cycle read latency.
module pim_alu_ctrl
  import pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src_a,
  input  logic [ADDR_WIDTH-1:0] cmd_src_b,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  ctrl_state_e           state_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_a_q;
  logic [ADDR_WIDTH-1:0] src_b_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] reg_a_q;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [ADDR_WIDTH-1:0] idx_ext;
  logic                  last_elem;

  assign idx_ext   = ADDR_WIDTH'(idx_q);
  assign last_elem = (idx_q == len_q - LEN_WIDTH'(1));

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so a command held valid while busy simply waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      reg_a_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
            len_q   <= cmd_len;
            idx_q   <= '0;
            state_q <= (cmd_len == '0) ? ST_DONE : ST_RD_A;
          end
        end
        ST_RD_A: state_q <= ST_RD_B;
        ST_RD_B: begin
          // Read data for the A fetch issued last cycle is on the bus now.
          reg_a_q <= mem_rd_data;
          state_q <= ST_WR;
        end
        ST_WR: begin
          if (last_elem) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + LEN_WIDTH'(1);
            state_q <= ST_RD_A;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pim_alu_ctrl_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op(op_q),
    .a (reg_a_q),
    .b (mem_rd_data),
    .y (alu_y)
  );

  // Bank strobes are gated with rst_n so a reset cycle never touches memory.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (rst_n) begin
      case (state_q)
        ST_RD_A: begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = src_a_q + idx_ext;
        end
        ST_RD_B: begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = src_b_q + idx_ext;
        end
        ST_WR: begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = dst_q + idx_ext;
          mem_wr_data = alu_y;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule
